// File: rtl/spi_sram_ctrl_if.sv
// SPI bus between an external master and the spi_sram_ctrl slave front end.
interface spi_sram_ctrl_if;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;

  modport master (
    output sclk,
    output cs_n,
    output mosi,
    input  miso
  );

  modport slave (
    input  sclk,
    input  cs_n,
    input  mosi,
    output miso
  );
endinterface

// File: rtl/spi_sram_ctrl.sv
// SPI mode-0 slave that turns READ/WRITE commands into sram address/IO/RE/WE cycles.
// Define SPI_SRAM_SEQ_EN for sequential (auto-increment) mode; the default is one byte per transaction.
module spi_sram_ctrl #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_sram_ctrl_if.slave    spi,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_io,
  output logic              sram_re,
  output logic              sram_we
);

  localparam logic [7:0] OpRead  = 8'h03;
  localparam logic [7:0] OpWrite = 8'h02;

`ifdef SPI_SRAM_SEQ_EN
  localparam bit SeqEn = 1'b1;
`else
  localparam bit SeqEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    StIdle, StCmd, StAddr, StWrData, StWrStrobe, StRdFetch, StRdShift, StIgnore
  } state_e;

  state_e              state_q;
  logic [2:0]          sclk_sync_q;
  logic [2:0]          cs_sync_q;
  logic [1:0]          mosi_sync_q;
  logic [15:0]         sh_q;
  logic [2:0]          bit_cnt_q;
  logic                addr_hi_q;
  logic                is_rd_q;
  logic                fetch_cnt_q;
  logic [ADDR_W-1:0]   sram_addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rd_sh_q;
  logic                re_q;
  logic                we_q;
  logic                miso_q;

  logic        sclk_rise;
  logic        sclk_fall;
  logic        cs_fall;
  logic        cs_high;
  logic [15:0] sh_nxt;
  logic        unused_sh_msb;

  // Sync flops reset low so a cs_n already low at reset release never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], spi.sclk};
      cs_sync_q   <= {cs_sync_q[1:0], spi.cs_n};
      mosi_sync_q <= {mosi_sync_q[0], spi.mosi};
    end
  end

  assign sclk_rise     = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall     = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_fall       = ~cs_sync_q[1] & cs_sync_q[2];
  assign cs_high       = cs_sync_q[1];
  assign sh_nxt        = {sh_q[14:0], mosi_sync_q[1]};
  assign unused_sh_msb = sh_q[15];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sh_q        <= '0;
      bit_cnt_q   <= '0;
      addr_hi_q   <= 1'b0;
      is_rd_q     <= 1'b0;
      fetch_cnt_q <= 1'b0;
      sram_addr_q <= '0;
      wdata_q     <= '0;
      rd_sh_q     <= '0;
      re_q        <= 1'b0;
      we_q        <= 1'b0;
      miso_q      <= 1'b0;
    end else if (state_q != StIdle && cs_high) begin
      // Deselect aborts whatever is in flight; a partial write byte is simply dropped.
      state_q <= StIdle;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      miso_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cs_fall) begin
            state_q   <= StCmd;
            bit_cnt_q <= '0;
            addr_hi_q <= 1'b0;
          end
        end
        StCmd: begin
          if (sclk_rise) begin
            sh_q      <= sh_nxt;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              is_rd_q <= (sh_nxt[7:0] == OpRead);
              state_q <= (sh_nxt[7:0] == OpRead || sh_nxt[7:0] == OpWrite) ? StAddr : StIgnore;
            end
          end
        end
        StAddr: begin
          if (sclk_rise) begin
            sh_q      <= sh_nxt;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              addr_hi_q <= 1'b1;
              if (addr_hi_q) begin
                sram_addr_q <= sh_nxt[ADDR_W-1:0];
                if (is_rd_q) begin
                  state_q     <= StRdFetch;
                  re_q        <= 1'b1;
                  fetch_cnt_q <= 1'b0;
                end else begin
                  state_q <= StWrData;
                end
              end
            end
          end
        end
        StWrData: begin
          if (sclk_rise) begin
            sh_q      <= sh_nxt;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              wdata_q <= sh_nxt[DATA_W-1:0];
              we_q    <= 1'b1;
              state_q <= StWrStrobe;
            end
          end
        end
        StWrStrobe: begin
          we_q <= 1'b0;
          if (SeqEn) begin
            sram_addr_q <= sram_addr_q + ADDR_W'(1);
            state_q     <= StWrData;
          end else begin
            state_q <= StIgnore;
          end
        end
        StRdFetch: begin
          // RE is held for two clocks; data is taken at the end of the second.
          if (!fetch_cnt_q) begin
            fetch_cnt_q <= 1'b1;
          end else begin
            rd_sh_q <= sram_io;
            re_q    <= 1'b0;
            state_q <= StRdShift;
            if (SeqEn) begin
              sram_addr_q <= sram_addr_q + ADDR_W'(1);
            end
          end
        end
        StRdShift: begin
          if (sclk_fall) begin
            miso_q  <= rd_sh_q[DATA_W-1];
            rd_sh_q <= {rd_sh_q[DATA_W-2:0], 1'b0};
          end
          if (sclk_rise) begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (SeqEn) begin
                state_q     <= StRdFetch;
                re_q        <= 1'b1;
                fetch_cnt_q <= 1'b0;
              end else begin
                state_q <= StIgnore;
                miso_q  <= 1'b0;
              end
            end
          end
        end
        StIgnore: begin
          miso_q <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign sram_addr = sram_addr_q;
  assign sram_re   = re_q;
  assign sram_we   = we_q;
  assign sram_io   = we_q ? wdata_q : {DATA_W{1'bz}};
  assign spi.miso  = miso_q;

endmodule

// File: tb/tb_spi_sram_ctrl.sv
// Randomized scoreboard bench for spi_sram_ctrl; follows SPI_SRAM_SEQ_EN when defined.
module tb_spi_sram_ctrl;

`ifdef SPI_SRAM_SEQ_EN
  localparam bit Seq = 1'b1;
`else
  localparam bit Seq = 1'b0;
`endif
  localparam int Half = 5;  // clk cycles per SPI half period

  typedef struct packed {
    logic [12:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] sram_addr;
  wire  [7:0]  sram_io;
  logic        sram_re;
  logic        sram_we;

  always #5 clk = ~clk;

  spi_sram_ctrl_if spi ();

  spi_sram_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .spi      (spi),
    .sram_addr(sram_addr),
    .sram_io  (sram_io),
    .sram_re  (sram_re),
    .sram_we  (sram_we)
  );

  // Simple model of the downstream sram array.
  logic [7:0] sram_mem [0:8191] = '{default: 8'h00};
  assign sram_io = sram_re ? sram_mem[sram_addr] : 8'bz;
  always @(posedge clk) if (sram_we) sram_mem[sram_addr] <= sram_io;

  // Reference model state and scoreboard queues.
  logic [7:0] ref_mem [0:8191] = '{default: 8'h00};
  wr_t        exp_wr[$];
  logic [7:0] exp_rd[$];
  logic [7:0] tx_buf [0:15];

  int   checks = 0;
  int   errors = 0;
  int   we_events = 0;
  int   quiet_viol = 0;
  bit   quiet = 1'b0;
  bit   rd_phase = 1'b0;
  bit   prev_we = 1'b0;
  int   rd_bits = 0;
  logic [7:0] rd_byte = 8'h00;
  wr_t  e_wr;
  logic [7:0] e_rd;

  always @(negedge clk) begin
    if (sram_we) begin
      we_events++;
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL we_unexpected: addr=%h data=%h, required no write", sram_addr, sram_io);
      end else begin
        e_wr = exp_wr.pop_front();
        if (sram_addr !== e_wr.addr || sram_io !== e_wr.data || sram_re !== 1'b0 || prev_we) begin
          errors++;
          $display("FAIL we_event: addr=%h data=%h re=%b prev_we=%b, required addr=%h data=%h re=0",
                   sram_addr, sram_io, sram_re, prev_we, e_wr.addr, e_wr.data);
        end
      end
    end
    prev_we = sram_we;
    if (quiet && (sram_re || sram_we || spi.miso)) quiet_viol++;
  end

  always @(posedge spi.sclk) begin
    if (rd_phase) begin
      rd_byte = {rd_byte[6:0], spi.miso};
      rd_bits++;
      if (rd_bits == 8) begin
        rd_bits = 0;
        checks++;
        if (exp_rd.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected: got %h, required no read byte", rd_byte);
        end else begin
          e_rd = exp_rd.pop_front();
          if (rd_byte !== e_rd) begin
            errors++;
            $display("FAIL rd_byte: got %h required %h", rd_byte, e_rd);
          end
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_begin();
    spi.cs_n = 1'b0;
    wait_clk(Half);
  endtask

  task automatic spi_end();
    wait_clk(Half);
    spi.cs_n = 1'b1;
    wait_clk(4 * Half);
  endtask

  task automatic spi_bits(input int nbits, input bit is_rd);
    for (int i = 0; i < nbits; i++) begin
      spi.mosi = tx_buf[i / 8][7 - (i % 8)];
      wait_clk(Half);
      rd_phase = is_rd && (i >= 24);
      spi.sclk = 1'b1;
      wait_clk(Half);
      spi.sclk = 1'b0;
    end
    rd_phase = 1'b0;
  endtask

  // Caller fills tx_buf[3..] with data bytes.
  task automatic do_write(input logic [15:0] a, input int n);
    wr_t w;
    tx_buf[0] = 8'h02;
    tx_buf[1] = a[15:8];
    tx_buf[2] = a[7:0];
    for (int i = 0; i < n; i++) begin
      if (Seq || i == 0) begin
        w.addr = 13'((int'(a[12:0]) + i) % 8192);
        w.data = tx_buf[3 + i];
        exp_wr.push_back(w);
        ref_mem[w.addr] = w.data;
      end
    end
    spi_begin();
    spi_bits(24 + 8 * n, 1'b0);
    spi_end();
  endtask

  task automatic do_read(input logic [15:0] a, input int n);
    tx_buf[0] = 8'h03;
    tx_buf[1] = a[15:8];
    tx_buf[2] = a[7:0];
    for (int i = 0; i < n; i++) begin
      tx_buf[3 + i] = 8'($urandom);
      exp_rd.push_back((Seq || i == 0) ? ref_mem[(int'(a[12:0]) + i) % 8192] : 8'h00);
    end
    spi_begin();
    spi_bits(24 + 8 * n, 1'b1);
    spi_end();
  endtask

  logic [15:0] ra;
  logic [15:0] last_a;
  int          rn;
  int          we_before;

  initial begin
    spi.cs_n = 1'b1;
    spi.sclk = 1'b0;
    spi.mosi = 1'b0;
    wait_clk(4);
    chk("reset_addr", int'(sram_addr), 0);
    chk("reset_re_we_miso", int'({sram_re, sram_we, spi.miso}), 0);
    rst_n = 1'b1;
    wait_clk(4);

    // Basic write then read back.
    tx_buf[3] = 8'hA5;
    do_write(16'h0001, 1);
    do_read(16'h0001, 1);

    // Wrap across the top of the array.
    tx_buf[3] = 8'h11; tx_buf[4] = 8'h22; tx_buf[5] = 8'h33;
    do_write(16'h1FFE, 3);
    do_read(16'h1FFF, 2);

    // Upper address bits ignored.
    tx_buf[3] = 8'h3C;
    do_write(16'hE005, 1);
    do_read(16'h0005, 1);

    // Unknown opcode: no sram activity and miso held low.
    tx_buf[0] = 8'h9F;
    for (int i = 1; i < 4; i++) tx_buf[i] = 8'($urandom);
    we_before  = we_events;
    quiet_viol = 0;
    quiet      = 1'b1;
    spi_begin();
    spi_bits(32, 1'b0);
    spi_end();
    quiet = 1'b0;
    chk("ignore_quiet", quiet_viol, 0);

    // Deselect mid-byte: the partial write byte is dropped.
    tx_buf[0] = 8'h02; tx_buf[1] = 8'h00; tx_buf[2] = 8'h10; tx_buf[3] = 8'h5A;
    we_before = we_events;
    spi_begin();
    spi_bits(28, 1'b0);
    spi_end();
    chk("partial_no_we", we_events - we_before, 0);
    do_read(16'h0010, 1);

    // Two-byte write: only one byte lands unless sequential mode is on.
    tx_buf[3] = 8'h6B; tx_buf[4] = 8'hC7;
    do_write(16'h0002, 2);
    do_read(16'h0003, 1);

    // Reset while shifting read data out.
    tx_buf[3] = 8'hFF;
    do_write(16'h0123, 1);
    tx_buf[0] = 8'h03; tx_buf[1] = 8'h01; tx_buf[2] = 8'h23; tx_buf[3] = 8'h00;
    spi_begin();
    spi_bits(27, 1'b0);
    wait_clk(4);
    chk("pre_reset_miso", int'(spi.miso), 1);
    chk("pre_reset_addr", int'(sram_addr), Seq ? 32'h124 : 32'h123);
    rst_n = 1'b0;
    wait_clk(1);
    chk("rst_re_miso", int'({sram_re, spi.miso}), 0);
    chk("rst_addr", int'(sram_addr), 0);
    rst_n      = 1'b1;
    quiet_viol = 0;
    quiet      = 1'b1;
    spi_bits(21, 1'b0);
    spi_end();
    quiet = 1'b0;
    chk("post_reset_quiet", quiet_viol, 0);

    // Randomized traffic.
    last_a = 16'h0001;
    for (int k = 0; k < 16; k++) begin
      ra = (k % 2 == 1) ? last_a : 16'($urandom);
      rn = Seq ? int'($urandom_range(1, 3)) : int'($urandom_range(1, 2));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < rn; i++) tx_buf[3 + i] = 8'($urandom);
        do_write(ra, rn);
        last_a = ra;
      end else begin
        do_read(ra, rn);
      end
    end

    chk("writes_drained", exp_wr.size(), 0);
    chk("reads_drained", exp_rd.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
